// File: rtl/cnn_conv2_mac_acc.sv
// conv2 MAC accumulator: sums NUM_TERMS signed products per pixel, adds bias,
// rounds/shifts, applies ReLU + saturation and hands the activation downstream.
module cnn_conv2_mac_acc #(
  parameter int PROD_WIDTH = 23,
  parameter int BIAS_WIDTH = 14,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_TERMS  = 150,
  parameter int SHIFT      = 8,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  in_last,
  input  logic [BIAS_WIDTH-1:0] bias_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  err_last
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam int AW1   = ACC_WIDTH + 1;

  localparam logic [1:0] S_ACCUM  = 2'd0;
  localparam logic [1:0] S_FINISH = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;

  localparam logic signed [AW1-1:0] RND     = AW1'(2 ** (SHIFT - 1));
  localparam logic signed [AW1-1:0] OUT_MAX = AW1'(2 ** (OUT_WIDTH - 1) - 1);

  logic [1:0]                  r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]            r_cnt;
  logic [BIAS_WIDTH-1:0]       r_bias;
  logic                        r_out_valid;
  logic [OUT_WIDTH-1:0]        r_out_data;
  logic                        r_err;

  logic                        w_in_fire;
  logic                        w_out_fire;
  logic                        w_last_term;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [AW1-1:0]       w_t;
  logic signed [AW1-1:0]       w_r;
  logic [OUT_WIDTH-1:0]        w_sat;

  // Gated by reset so upstream sees not-ready for the whole reset window.
  assign in_ready    = (r_state == S_ACCUM) && ap_rst_n;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign err_last    = r_err;

  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_last_term = (r_cnt == CNT_W'(NUM_TERMS - 1));
  assign w_prod_ext  = {{(ACC_WIDTH - PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};

  // Round-half-up then arithmetic shift; one guard bit keeps the sum exact.
  assign w_t = {r_acc[ACC_WIDTH-1], r_acc}
             + {{(AW1 - BIAS_WIDTH){r_bias[BIAS_WIDTH-1]}}, r_bias}
             + RND;
  assign w_r = w_t >>> SHIFT;

  always_comb begin
    w_sat = w_r[OUT_WIDTH-1:0];
    if (w_r[AW1-1]) begin
      w_sat = '0;
    end else if (w_r > OUT_MAX) begin
      w_sat = OUT_MAX[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_bias      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_in_fire) begin
            if (r_cnt == '0) begin
              r_acc  <= w_prod_ext;
              r_bias <= bias_in;
            end else begin
              r_acc <= r_acc + w_prod_ext;
            end
            if (w_last_term) begin
              r_cnt   <= '0;
              r_state <= S_FINISH;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            // Count decides completion; in_last only feeds the sticky flag.
            if (in_last != w_last_term) begin
              r_err <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_state     <= S_ACCUM;
          end
        end
        default: begin
          r_state <= S_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv2_mac_acc.sv
// Bench for cnn_conv2_mac_acc: directed and random pixels against an
// arithmetic reference of bias/round/shift/ReLU/saturate.
module tb_cnn_conv2_mac_acc;

  localparam int PW = 23;
  localparam int BW = 14;
  localparam int AW = 32;
  localparam int NT = 150;
  localparam int SH = 8;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_prod;
  logic          in_last;
  logic [BW-1:0] bias_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          err_last;

  int cyc = 0;
  int acc_cyc = 0;
  int n_total = 0;
  int n_bad = 0;
  int prods[NT];

  cnn_conv2_mac_acc #(
    .PROD_WIDTH(PW), .BIAS_WIDTH(BW), .ACC_WIDTH(AW),
    .NUM_TERMS(NT), .SHIFT(SH), .OUT_WIDTH(OW)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_last(in_last), .bias_in(bias_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_last(err_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: whole-pixel sum, then requantise with plain integer arithmetic.
  function automatic int ref_act(input int b);
    longint s = 0;
    longint r;
    foreach (prods[i]) s += prods[i];
    r = (s + b + (longint'(1) <<< (SH - 1))) >>> SH;
    if (r < 0) return 0;
    if (r > (2 ** (OW - 1) - 1)) return 2 ** (OW - 1) - 1;
    return int'(r);
  endfunction

  task automatic put(input int p, input int b, input bit last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = PW'(p);
    bias_in  = BW'(b);
    in_last  = last;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_out(input int exp, input int hold);
    int n = 0;
    logic [OW-1:0] d;
    @(negedge clk);
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("out_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", cyc - acc_cyc, 2);
    chk("out_data", 32'(out_data), exp);
    d = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_prod  = PW'(7);
      @(negedge clk);
      chk("hold_data", 32'(out_data), 32'(d));
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("post_out_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
  endtask

  // exp < 0 selects the reference model; non-first terms carry junk bias.
  task automatic pixel(input int b, input int gapmax, input int last_at,
                       input int hold, input int exp);
    int e;
    e = (exp < 0) ? ref_act(b) : exp;
    for (int i = 0; i < NT; i++) begin
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) @(negedge clk);
      put(prods[i], (i == 0) ? b : int'($urandom_range(0, 16383)) - 8192, i == last_at);
    end
    get_out(e, hold);
  endtask

  task automatic fill(input int v);
    foreach (prods[i]) prods[i] = v;
  endtask

  task automatic fill_rand(input int lo, input int hi);
    foreach (prods[i]) prods[i] = int'($urandom_range(0, hi - lo)) + lo;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
    bias_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_err", 32'(err_last), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 1);

    fill(1);                          pixel(0, 0, NT - 1, 0, 1);
    fill(0); prods[NT-1] = 128;       pixel(0, 0, NT - 1, 0, 1);
    fill(0); prods[NT-1] = 127;       pixel(0, 0, NT - 1, 0, 0);
    fill(256);                        pixel(0, 0, NT - 1, 0, 127);
    fill(-256);                       pixel(0, 0, NT - 1, 0, 0);
    fill(0);                          pixel(-129, 0, NT - 1, 0, 0);
    fill(0);                          pixel(383, 0, NT - 1, 0, 1);

    fill_rand(-300, 520);             pixel(-500, 0, NT - 1, 5, -1);

    for (int k = 0; k < 3; k++) begin
      fill_rand(-300, 520);
      pixel(int'($urandom_range(0, 16383)) - 8192, 3, NT - 1, 0, -1);
    end
    fill_rand(-(2 ** 22), 2 ** 22 - 1);
    pixel(int'($urandom_range(0, 16383)) - 8192, 1, NT - 1, 0, -1);
    chk("err_clean", 32'(err_last), 0);

    fill_rand(-300, 520);             pixel(1000, 0, 100, 0, -1);
    chk("err_set", 32'(err_last), 1);
    fill_rand(-300, 520);             pixel(-1000, 0, NT - 1, 0, -1);
    chk("err_sticky", 32'(err_last), 1);

    fill_rand(2000, 4000);
    for (int i = 0; i < 70; i++) put(prods[i], 100, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_err", 32'(err_last), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_rand(-300, 520);             pixel(77, 2, NT - 1, 0, -1);
    chk("err_after_rst", 32'(err_last), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
